// File: rtl/tia_horizontal_sequencer.sv
// TIA horizontal timing chain: biphase enables, 57-state line counter, line decodes
// and the WSYNC/RDY, RSYNC and HMOVE line-control strobes.
module tia_horizontal_sequencer #(
  parameter int unsigned LINE_COUNTS  = 57,
  parameter int unsigned HSYNC_START  = 4,
  parameter int unsigned HSYNC_END    = 8,
  parameter int unsigned CBURST_START = 8,
  parameter int unsigned CBURST_END   = 12,
  parameter int unsigned HBLANK_END   = 17,
  parameter int unsigned HMOVE_EXT    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rsync,
  input  logic       wsync,
  input  logic       hmove,
  output logic       hphi1,
  output logic       hphi2,
  output logic [5:0] hcount,
  output logic       hsync,
  output logic       hblank,
  output logic       cburst,
  output logic       rdy,
  output logic       line_start
);

  localparam logic [5:0] LastCount    = 6'(LINE_COUNTS - 1);
  localparam logic [5:0] HsyncStart   = 6'(HSYNC_START);
  localparam logic [5:0] HsyncEnd     = 6'(HSYNC_END);
  localparam logic [5:0] CburstStart  = 6'(CBURST_START);
  localparam logic [5:0] CburstEnd    = 6'(CBURST_END);
  localparam logic [5:0] HblankEnd    = 6'(HBLANK_END);
  localparam logic [5:0] HblankExtEnd = 6'(HBLANK_END + HMOVE_EXT);
  // Last count still covered by the extended blank; the latch drops leaving it.
  localparam logic [5:0] HmoveClrCnt  = 6'(HBLANK_END + HMOVE_EXT - 1);

  logic [1:0] phase_q, phase_d;
  logic [5:0] hcount_q, hcount_d;
  logic       hmove_latch_q, hmove_latch_d;
  logic       rdy_q, rdy_d;
  logic       line_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= 2'd0;
      hcount_q      <= 6'd0;
      hmove_latch_q <= 1'b0;
      rdy_q         <= 1'b1;
    end else begin
      phase_q       <= phase_d;
      hcount_q      <= hcount_d;
      hmove_latch_q <= hmove_latch_d;
      rdy_q         <= rdy_d;
    end
  end

  always_comb begin
    phase_d       = phase_q + 2'd1;
    hcount_d      = hcount_q;
    line_evt      = 1'b0;
    hmove_latch_d = hmove_latch_q;
    rdy_d         = rdy_q;

    if (phase_q == 2'd3) begin
      if (hcount_q == LastCount) begin
        hcount_d = 6'd0;
        line_evt = 1'b1;
      end else begin
        hcount_d = hcount_q + 6'd1;
      end
    end

    if (rsync) begin
      phase_d  = 2'd0;
      hcount_d = 6'd0;
      line_evt = 1'b1;
    end

    // Clear only on a genuine advance out of the last extended count.
    if (!rsync && phase_q == 2'd3 && hcount_q == HmoveClrCnt) begin
      hmove_latch_d = 1'b0;
    end
    if (hmove) begin
      hmove_latch_d = 1'b1;
    end

    // A wsync on the line-start edge holds the CPU for the whole next line.
    if (line_evt) begin
      rdy_d = 1'b1;
    end
    if (wsync) begin
      rdy_d = 1'b0;
    end
  end

  always_comb begin
    hphi1      = (phase_q == 2'd0);
    hphi2      = (phase_q == 2'd2);
    hcount     = hcount_q;
    hsync      = (hcount_q >= HsyncStart) && (hcount_q < HsyncEnd);
    cburst     = (hcount_q >= CburstStart) && (hcount_q < CburstEnd);
    hblank     = hcount_q < (hmove_latch_q ? HblankExtEnd : HblankEnd);
    rdy        = rdy_q;
    line_start = (hcount_q == 6'd0) && (phase_q == 2'd0);
  end

endmodule

// File: tb/tb_tia_horizontal_sequencer.sv
// Bench for tia_horizontal_sequencer: colour-clock position model checked every
// cycle, directed line-timing scenarios with literal expectations, then random strobes.
module tb_tia_horizontal_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rsync = 1'b0;
  logic       wsync = 1'b0;
  logic       hmove = 1'b0;
  logic       hphi1, hphi2, hsync, hblank, cburst, rdy, line_start;
  logic [5:0] hcount;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: position within the 228-clk line, CPU ready, HMOVE latch.
  int m_pos   = 0;
  bit m_rdy   = 1'b1;
  bit m_latch = 1'b0;
  int np;

  tia_horizontal_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .rsync      (rsync),
    .wsync      (wsync),
    .hmove      (hmove),
    .hphi1      (hphi1),
    .hphi2      (hphi2),
    .hcount     (hcount),
    .hsync      (hsync),
    .hblank     (hblank),
    .cburst     (cburst),
    .rdy        (rdy),
    .line_start (line_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pos   <= 0;
      m_rdy   <= 1'b1;
      m_latch <= 1'b0;
    end else begin
      np = rsync ? 0 : (m_pos + 1) % 228;
      m_pos <= np;
      if (wsync) m_rdy <= 1'b0;
      else if (np == 0) m_rdy <= 1'b1;
      if (hmove) m_latch <= 1'b1;
      else if (m_pos / 4 == 18 && np / 4 == 19) m_latch <= 1'b0;
    end
  end

  always @(negedge clk) begin
    int hc, ph;
    hc = m_pos / 4;
    ph = m_pos % 4;
    check("hcount", int'(hcount), hc);
    check("hphi1", int'(hphi1), int'(ph == 0));
    check("hphi2", int'(hphi2), int'(ph == 2));
    check("hsync", int'(hsync), int'(hc >= 4 && hc < 8));
    check("cburst", int'(cburst), int'(hc >= 8 && hc < 12));
    check("hblank", int'(hblank), int'(hc < (m_latch ? 19 : 17)));
    check("rdy", int'(rdy), int'(m_rdy));
    check("line_start", int'(line_start), int'(m_pos == 0));
  end

  task automatic tick(input bit r, input bit w, input bit h);
    rsync = r;
    wsync = w;
    hmove = h;
    @(posedge clk);
    #1;
    rsync = 1'b0;
    wsync = 1'b0;
    hmove = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    int guard;
    guard = 0;
    while (m_pos != p && guard < 300) begin
      tick(1'b0, 1'b0, 1'b0);
      guard++;
    end
    if (m_pos != p) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_pos: got position %0d, expected %0d", m_pos, p);
    end
  endtask

  task automatic count_rdy_low(input string name, input int exp);
    int n, guard;
    n = 0;
    guard = 0;
    while (rdy == 1'b0 && guard < 300) begin
      n++;
      guard++;
      tick(1'b0, 1'b0, 1'b0);
    end
    check(name, n, exp);
    check({name, "_release_hcount"}, int'(hcount), 0);
  endtask

  task automatic count_hblank_line(input string name, input int hmove_at, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < 228; i++) begin
      if (hblank) n++;
      tick(1'b0, 1'b0, i == hmove_at);
    end
    check(name, n, exp);
  endtask

  initial begin
    int n_hs, n_cb, n_hb, n_ls, n_p1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hphi1", int'(hphi1), 1);
    check("rst_hphi2", int'(hphi2), 0);
    check("rst_hblank", int'(hblank), 1);
    check("rst_line_start", int'(line_start), 1);
    check("rst_rdy", int'(rdy), 1);
    check("rst_hcount", int'(hcount), 0);
    reset = 1'b0;

    // Free run two lines.
    n_hs = 0; n_cb = 0; n_hb = 0; n_ls = 0; n_p1 = 0;
    for (int k = 1; k <= 456; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (k <= 228) begin
        n_hs += int'(hsync);
        n_cb += int'(cburst);
        n_hb += int'(hblank);
      end
      n_ls += int'(line_start);
      n_p1 += int'(hphi1);
      if (k == 16) check("free_hcount_at16", int'(hcount), 4);
      if (k == 227) check("free_hcount_at227", int'(hcount), 56);
      if (k == 228) check("free_wrap_line_start", int'(line_start), 1);
      if (k == 230) check("free_hphi2_at230", int'(hphi2), 1);
    end
    check("free_hsync_clks", n_hs, 16);
    check("free_cburst_clks", n_cb, 16);
    check("free_hblank_clks", n_hb, 68);
    check("free_line_starts", n_ls, 2);
    check("free_hphi1_count", n_p1, 114);

    // WSYNC mid-line, then on the wrap edge.
    wait_pos(120);
    tick(1'b0, 1'b1, 1'b0);
    count_rdy_low("wsync_mid_low_clks", 107);
    wait_pos(227);
    tick(1'b0, 1'b1, 1'b0);
    count_rdy_low("wsync_wrap_low_clks", 228);

    // HMOVE early in the line, then late in the line.
    wait_pos(0);
    count_hblank_line("hmove_early_hblank", 4, 76);
    count_hblank_line("hmove_cleared_hblank", -1, 68);
    wait_pos(160);
    tick(1'b0, 1'b0, 1'b1);
    wait_pos(0);
    count_hblank_line("hmove_late_next_hblank", -1, 76);

    // RSYNC at hcount 25 phase 2 releases a pending wsync.
    wait_pos(90);
    tick(1'b0, 1'b1, 1'b0);
    wait_pos(102);
    check("rsync_pre_rdy", int'(rdy), 0);
    tick(1'b1, 1'b0, 1'b0);
    check("rsync_hcount", int'(hcount), 0);
    check("rsync_hphi1", int'(hphi1), 1);
    check("rsync_line_start", int'(line_start), 1);
    check("rsync_rdy_released", int'(rdy), 1);
    wait_pos(50);
    tick(1'b1, 1'b1, 1'b0);
    check("rsync_wsync_hcount", int'(hcount), 0);
    check("rsync_wsync_rdy", int'(rdy), 0);

    // Asynchronous reset at hcount 20 with rdy low and latch set.
    wait_pos(70);
    tick(1'b0, 1'b0, 1'b1);
    wait_pos(80);
    check("prereset_rdy", int'(rdy), 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_hcount", int'(hcount), 0);
    check("async_rst_rdy", int'(rdy), 1);
    check("async_rst_hblank", int'(hblank), 1);
    check("async_rst_hphi1", int'(hphi1), 1);
    check("async_rst_line_start", int'(line_start), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (72) tick(1'b0, 1'b0, 1'b0);
    check("postreset_hcount18", int'(hcount), 18);
    check("postreset_latch_cleared", int'(hblank), 0);

    // Random strobes with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) begin
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
      end else begin
        tick($urandom_range(63) == 0, $urandom_range(31) == 0, $urandom_range(31) == 0);
      end
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
